// File: rtl/vga_timing_ctrl.sv
// vga_timing_ctrl: 640x480 VGA raster timing source for the pixel path.
//   Free-running hcount/vcount drive the color generator; sync and display
//   enable are delayed two clocks so they line up with the generator's
//   registered color, which is blanked outside the active area.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   pix_en            pixel tick; counters advance only when high
//   hcount, vcount    raster position (registered)
//   r_in/g_in/b_in    color from the generator, one clk after hcount/vcount
//   r/g/b             blanked color to the pins
//   hsync, vsync      active-low syncs, aligned with r/g/b
//   frame_start       one-clk pulse after the (H_TOTAL-1,V_TOTAL-1) tick
// Optional feature: define VGA_BORDER_EN to force white on the active-area border.
`timescale 1ns/1ps
module vga_timing_ctrl #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pix_en,
  output logic [10:0] hcount,
  output logic [9:0]  vcount,
  input  logic [1:0]  r_in,
  input  logic [1:0]  g_in,
  input  logic [1:0]  b_in,
  output logic [1:0]  r,
  output logic [1:0]  g,
  output logic [1:0]  b,
  output logic        hsync,
  output logic        vsync,
  output logic        frame_start
);

  localparam int unsigned HW = 11;
  localparam int unsigned VW = 10;
  localparam int unsigned CW = 2;
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);
`ifdef VGA_BORDER_EN
  localparam logic [HW-1:0] H_ACT_LAST = HW'(H_ACTIVE - 1);
  localparam logic [VW-1:0] V_ACT_LAST = VW'(V_ACTIVE - 1);
`endif

  logic [HW-1:0] hcount_q, hcount_d;
  logic [VW-1:0] vcount_q, vcount_d;
  logic          frame_start_q, frame_start_d;
  logic          h_wrap_c, v_wrap_c;
  logic          de0_c, hs0_c, vs0_c;
  logic          de1_q, hs1_q, vs1_q;
  logic [CW-1:0] r_q, g_q, b_q, r_d, g_d, b_d;
  logic          hsync_q, vsync_q;
`ifdef VGA_BORDER_EN
  logic          bd0_c, bd1_q;
`endif

  // Raster counters and frame pulse next-state
  always_comb begin
    hcount_d      = hcount_q;
    vcount_d      = vcount_q;
    h_wrap_c      = (hcount_q == H_LAST);
    v_wrap_c      = (vcount_q == V_LAST);
    frame_start_d = pix_en && h_wrap_c && v_wrap_c;
    if (pix_en) begin
      if (h_wrap_c) begin
        hcount_d = '0;
        vcount_d = v_wrap_c ? '0 : vcount_q + VW'(1);
      end else begin
        hcount_d = hcount_q + HW'(1);
      end
    end
  end

  // Stage-0 decode straight from the counters
  always_comb begin
    de0_c = (hcount_q < H_ACT) && (vcount_q < V_ACT);
    hs0_c = !((hcount_q >= HS_BEG) && (hcount_q < HS_END));
    vs0_c = !((vcount_q >= VS_BEG) && (vcount_q < VS_END));
`ifdef VGA_BORDER_EN
    bd0_c = de0_c && ((hcount_q == '0) || (hcount_q == H_ACT_LAST) ||
                      (vcount_q == '0) || (vcount_q == V_ACT_LAST));
`endif
  end

  // Stage-2 color select: blank outside active area (border overrides)
  always_comb begin
    r_d = '0;
    g_d = '0;
    b_d = '0;
    if (de1_q) begin
      r_d = r_in;
      g_d = g_in;
      b_d = b_in;
    end
`ifdef VGA_BORDER_EN
    if (bd1_q) begin
      r_d = '1;
      g_d = '1;
      b_d = '1;
    end
`endif
  end

  // Counters gated by pix_en; both pipeline stages run every clk
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hcount_q      <= '0;
      vcount_q      <= '0;
      frame_start_q <= 1'b0;
      de1_q         <= 1'b0;
      hs1_q         <= 1'b1;
      vs1_q         <= 1'b1;
      r_q           <= '0;
      g_q           <= '0;
      b_q           <= '0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
    end else begin
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      frame_start_q <= frame_start_d;
      de1_q         <= de0_c;
      hs1_q         <= hs0_c;
      vs1_q         <= vs0_c;
      r_q           <= r_d;
      g_q           <= g_d;
      b_q           <= b_d;
      hsync_q       <= hs1_q;
      vsync_q       <= vs1_q;
    end
  end

`ifdef VGA_BORDER_EN
  always_ff @(posedge clk) begin
    if (!rst_n) bd1_q <= 1'b0;
    else        bd1_q <= bd0_c;
  end
`endif

  assign hcount      = hcount_q;
  assign vcount      = vcount_q;
  assign frame_start = frame_start_q;
  assign r           = r_q;
  assign g           = g_q;
  assign b           = b_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;

endmodule

// File: doc/vga_timing_ctrl.md
# vga_timing_ctrl

- Generates the 640x480 VGA raster for the pixel path.
- Its free-running `hcount`/`vcount` counters drive the color generator.
- It pipelines `hsync`/`vsync`/display-enable to match the color generator's one-clock registered latency.
- It blanks the color generator's 2-bit RGB outside the active area before the pins.
- It sits between the color generator and the board DAC/connector, and is the only timing source in the video path.

## Interface

Parameters:
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, hsync pulse width (pixels)
- `H_BP`, 48, horizontal back porch (pixels)
- `V_ACTIVE`, 480, visible lines per frame
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vsync pulse width (lines)
- `V_BP`, 33, vertical back porch (lines)

Ports:
- `clk`  in  1  system clock; one clock domain; all logic on posedge
- `rst_n`  in  1  synchronous, active-low reset
- `pix_en`  in  1  pixel tick; counters advance only on cycles where it is high
- `hcount`  out  11  horizontal position, 0..H_TOTAL-1, registered
- `vcount`  out  10  vertical position, 0..V_TOTAL-1, registered
- `r_in`, `g_in`, `b_in`  in  2 each  color generator output; registered one clk after `hcount`/`vcount`
- `r`, `g`, `b`  out  2 each  blanked color to the pins
- `hsync`, `vsync`  out  1 each  active-low sync, aligned to `r/g/b`
- `frame_start`  out  1  one-clk pulse when the counters wrap to (0,0)

## Operation

- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Counter rules, applied on a `pix_en`=1 cycle:
  - `hcount` increments; at H_TOTAL-1 it wraps to 0.
  - `vcount` increments only on that `hcount` wrap; at V_TOTAL-1 with the `hcount` wrap it wraps to 0.
  - With `pix_en`=0, both counters hold.
- Stage-0 decode, combinational from the counters:
  - de0 = (hcount < H_ACTIVE) && (vcount < V_ACTIVE)
  - hs0 = !(hcount in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC)), giving low for 656..751
  - vs0 = !(vcount in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC)), giving low for lines 490..491
- Stage 1: de1/hs1/vs1 are registered from stage 0 every clk, not gated by `pix_en`. This matches the color generator's register.
- Stage 2 (outputs), registered every clk:
  - `hsync` <= hs1, `vsync` <= vs1
  - `r` <= de1 ? `r_in` : 0; same for `g` and `b`
- `frame_start` is registered. It is high for exactly one clk: the cycle after a `pix_en` cycle in which `hcount`=H_TOTAL-1 and `vcount`=V_TOTAL-1.
- Widths:
  - All comparisons are unsigned at counter width.
  - The parameters must satisfy H_TOTAL ≤ 2048 and V_TOTAL ≤ 1024. This is not checked in RTL.

## Timing

- Reset values, on a clk edge with `rst_n`=0:
  - `hcount`=0, `vcount`=0
  - de1=0, hs1=1, vs1=1
  - `r`=`g`=`b`=0, `hsync`=1, `vsync`=1, `frame_start`=0
- Reset overrides `pix_en`.
- Reset mid-frame: counters return to (0,0) on the next edge. Syncs return to inactive and RGB to 0 the same edge; no partial sync pulse is extended.
- The first edge after `rst_n` rises with `pix_en`=1 gives `hcount`=1.
- Latency:
  - counter value at edge t → `r_in` valid at t+1 → `r/g/b`, `hsync`, `vsync` at t+2
  - Sync and color are always co-aligned.
- With `pix_en` toggling 1/0 (50 MHz clk, 25 MHz pixel), each pixel is held 2 clk; the pipeline behavior is unchanged.
- Wrap: the (799,524)→(0,0) transition happens in one edge with no skipped or repeated count. `frame_start` fires once per frame.

## Configuration

- Macro: `VGA_BORDER_EN`.
- Defined:
  - A border flag bd0 = de0 && (hcount==0 || hcount==H_ACTIVE-1 || vcount==0 || vcount==V_ACTIVE-1).
  - bd0 is pipelined through stage 1 alongside de0.
  - At stage 2, bd1 forces `r`=`g`=`b`=3, overriding `r_in/g_in/b_in`.
  - Reset value of the border pipeline register is 0.
- Undefined: no border logic is present. Output is purely `de1 ? rgb_in : 0`.

## Test plan

- Reset: hold `rst_n`=0 for 3 clk with `pix_en`=1 → `hcount`=0, `vcount`=0, `hsync`=`vsync`=1, `r`=`g`=`b`=0, `frame_start`=0.
- Line timing: `pix_en`=1 continuously → `hcount` period 800 clk. `hsync` is low for 96 consecutive clk, starting 2 clk after `hcount`=656. `vcount` increments once per 800 clk.
- Frame timing: run 525×800 pix ticks →
  - `vsync` low for exactly 1600 pix ticks, starting 2 clk after the edge where `vcount` becomes 490
  - `frame_start` pulses once, on the (799,524)→(0,0) wrap
- Blanking: drive `r_in`=`g_in`=`b_in`=3 constantly →
  - `r`=3 for output cycles matching `hcount` 0..639
  - `r`=0 for 640..799 and for lines ≥480
- Pixel enable: `pix_en` alternating 1/0 → each `hcount` value is held exactly 2 clk; line period is 1600 clk; hsync low for 192 clk.
- Border and reset mid-frame:
  - With `VGA_BORDER_EN` and `r_in`=0: `r`=`g`=`b`=3 at (0,y), (639,y), (x,0), (x,479); 0 elsewhere in the active area.
  - Assert `rst_n`=0 at (300,200) → next edge gives (0,0) with outputs at their reset values.
